// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder: data-side scratchpad responder for the EX-stage memory request.
// It accepts one request in IDLE and commits writes on the acceptance edge. It then
// waits WAIT_CYCLES cycles and gives a one-cycle response strobe with the raw 32-bit word.
// Optional feature macro: CPU_DMEM_ERR_EN adds the bus_err port and an address range check.
module cpu_dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ce,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        data_valid,
  output logic        stall_req
`ifdef CPU_DMEM_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           hold_q;
  logic                  accept;
  logic                  addr_ok;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           acc_word;
  logic [31:0]           mem [DEPTH];

  assign idx = req_addr[ADDR_WIDTH+1:2];

  // Upper address bits alias and the byte offset is ignored; the range check is the only user.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

`ifdef CPU_DMEM_ERR_EN
  localparam logic [32:0] SPAN  = 33'(1) << (ADDR_WIDTH + 2);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;
  logic err_q;

  // Address is legal only inside [BASE_ADDR, BASE_ADDR + capacity).
  always_comb begin
    addr_ok = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr} < LIMIT);
  end
`else
  assign addr_ok = 1'b1;
`endif

  // Word returned for the request being accepted: writes and errored requests respond with zero.
  assign acc_word = (req_we || !addr_ok) ? 32'(0) : mem[idx];
  assign wr_en    = accept && req_we && addr_ok;

  // Hold the pipeline while a fresh request is presented in IDLE or a response is pending.
  assign stall_req = !rst && (((state_q == S_IDLE) && req_ce) || (state_q == S_WAIT));

  // Next-state logic: accept in IDLE, count wait states, and respond for exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_ce) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scratchpad byte-lane write at the acceptance edge; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && req_sel[i]) begin
        mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // State, wait counter and response registers; rdata changes only when entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_W'(0);
      hold_q     <= 32'(0);
      rdata      <= 32'(0);
      data_valid <= 1'b0;
`ifdef CPU_DMEM_ERR_EN
      err_q      <= 1'b0;
      bus_err    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_valid <= (state_d == S_RESP);
      if (accept) begin
        hold_q <= acc_word;
      end
      if (state_d == S_RESP) begin
        rdata <= accept ? acc_word : hold_q;
      end
`ifdef CPU_DMEM_ERR_EN
      if (accept) begin
        err_q <= !addr_ok;
      end
      bus_err <= (state_d == S_RESP) && (accept ? !addr_ok : err_q);
`endif
    end
  end

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Bench for cpu_dmem_responder: directed cases plus randomized traffic checked against
// a word-array reference model. CPU_DMEM_ERR_EN selects the range-checked variant.
module tb_cpu_dmem_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned TW    = 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned FILL  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ce;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        data_valid;
  logic        stall_req;
`ifdef CPU_DMEM_ERR_EN
  logic        bus_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];

  cpu_dmem_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(TW),
    .BASE_ADDR  (BASE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_ce    (req_ce),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .data_valid(data_valid),
    .stall_req (stall_req)
`ifdef CPU_DMEM_ERR_EN
    ,
    .bus_err   (bus_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef CPU_DMEM_ERR_EN
    longint unsigned lo, hi;
    lo = longint'(BASE);
    hi = lo + 4 * longint'(DEPTH);
    return (longint'(a) >= lo) && (longint'(a) < hi);
`else
    return (a == a);
`endif
  endfunction

  // One transaction starting just after a falling edge in an idle cycle. It checks stall
  // in every cycle, the response cycle, and that rdata holds afterwards. hold keeps req_ce high.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input bit hold);
    int          idx;
    bit          ok;
    logic [31:0] exp;
    idx = int'(addr[AW+1:2]);
    ok  = in_range(addr);
    if (we || !ok) exp = 32'h0;
    else           exp = model_mem[idx];
    if (we && ok) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    req_ce    = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_sel   = sel;
    req_wdata = wdata;
    #1;
    check("stall_accept", 32'(stall_req), 32'd1);
    check("dv_accept", 32'(data_valid), 32'd0);
    for (int k = 0; k < int'(TW); k++) begin
      @(negedge clk);
      #1;
      check("stall_wait", 32'(stall_req), 32'd1);
      check("dv_wait", 32'(data_valid), 32'd0);
    end
    @(negedge clk);
    #1;
    check("dv_resp", 32'(data_valid), 32'd1);
    check("stall_resp", 32'(stall_req), 32'd0);
    check("rdata_resp", rdata, exp);
`ifdef CPU_DMEM_ERR_EN
    check("bus_err_resp", 32'(bus_err), 32'(!ok));
`endif
    if (!hold) req_ce = 1'b0;
    @(negedge clk);
    #1;
    check("dv_after", 32'(data_valid), 32'd0);
    check("rdata_hold", rdata, exp);
`ifdef CPU_DMEM_ERR_EN
    check("bus_err_after", 32'(bus_err), 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] upper;
    logic [31:0] a;
    int          idx;

    rst       = 1'b1;
    req_ce    = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_sel   = 4'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall_forced", 32'(stall_req), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
`ifdef CPU_DMEM_ERR_EN
    check("rst_bus_err", 32'(bus_err), 32'd0);
`endif
    req_ce = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    #1;
    check("idle_stall", 32'(stall_req), 32'd0);

    // Fill the working region so every later read has a defined value.
    for (int i = 0; i < int'(FILL); i++) begin
      do_req(1'b1, BASE + 32'(i * 4), 4'hF, $urandom, 1'b0);
    end

    // Full write then read back.
    do_req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    check("dir_deadbeef", model_mem[4], 32'hDEAD_BEEF);

    // Single byte-lane update.
    do_req(1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0);
    do_req(1'b1, 32'h20, 4'b0100, 32'h00AA_0000, 1'b0);
    do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);

    // Back-to-back reads with req_ce held high between them.
    do_req(1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    do_req(1'b0, 32'h4, 4'hF, 32'h0, 1'b0);

    // Aliased (or out-of-range) write, then read of word 0.
    do_req(1'b1, 32'h1000, 4'hF, 32'h0000_0005, 1'b0);
    do_req(1'b0, 32'h0, 4'hF, 32'h0, 1'b0);

    // Empty lane mask completes without changing memory.
    do_req(1'b1, 32'h8, 4'hF, 32'h1234_5678, 1'b0);
    do_req(1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, 1'b0);
    do_req(1'b0, 32'h8, 4'hF, 32'h0, 1'b0);

    // Reset while a read is waiting cancels the response but keeps committed writes.
    req_ce   = 1'b1;
    req_we   = 1'b0;
    req_addr = 32'h10;
    req_sel  = 4'hF;
    @(negedge clk);
    #1;
    check("rstw_stall_wait", 32'(stall_req), 32'd1);
    rst    = 1'b1;
    req_ce = 1'b0;
    #1;
    check("rstw_stall", 32'(stall_req), 32'd0);
    check("rstw_dv", 32'(data_valid), 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstw_dv_post", 32'(data_valid), 32'd0);
    check("rstw_stall_post", 32'(stall_req), 32'd0);
    check("rstw_rdata_post", rdata, 32'd0);
    do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
    do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);

    // Randomized traffic over the filled region, with some upper-bit aliases.
    for (int n = 0; n < 150; n++) begin
      idx   = int'($urandom_range(0, FILL - 1));
      upper = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      a     = BASE | (upper << (AW + 2)) | 32'(idx * 4) | 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
             bit'($urandom_range(0, 1)));
    end

    req_ce = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
